// File: rtl/pcie_us_msi_ctrl_if.sv
// MSI side-band bundle between the interrupt controller and the
// UltraScale+ PCIe hard block (cfg_interrupt_msi_* signals).
// master: the controller; slave: the PCIe hard IP.
interface pcie_us_msi_ctrl_if;
  logic [3:0]  cfg_interrupt_msi_enable;
  logic [11:0] cfg_interrupt_msi_mmenable;
  logic [31:0] cfg_interrupt_msi_int;
  logic        cfg_interrupt_msi_sent;
  logic        cfg_interrupt_msi_fail;
  logic [31:0] cfg_interrupt_msi_pending_status;
  logic        cfg_interrupt_msi_pending_status_data_enable;
  logic [3:0]  cfg_interrupt_msi_pending_status_function_num;
  logic [3:0]  cfg_interrupt_msi_select;
  logic [3:0]  cfg_interrupt_msi_function_number;
  logic [2:0]  cfg_interrupt_msi_attr;
  logic        cfg_interrupt_msi_tph_present;
  logic [1:0]  cfg_interrupt_msi_tph_type;
  logic [8:0]  cfg_interrupt_msi_tph_st_tag;

  modport master (
    input  cfg_interrupt_msi_enable,
    input  cfg_interrupt_msi_mmenable,
    input  cfg_interrupt_msi_sent,
    input  cfg_interrupt_msi_fail,
    output cfg_interrupt_msi_int,
    output cfg_interrupt_msi_pending_status,
    output cfg_interrupt_msi_pending_status_data_enable,
    output cfg_interrupt_msi_pending_status_function_num,
    output cfg_interrupt_msi_select,
    output cfg_interrupt_msi_function_number,
    output cfg_interrupt_msi_attr,
    output cfg_interrupt_msi_tph_present,
    output cfg_interrupt_msi_tph_type,
    output cfg_interrupt_msi_tph_st_tag
  );

  modport slave (
    output cfg_interrupt_msi_enable,
    output cfg_interrupt_msi_mmenable,
    output cfg_interrupt_msi_sent,
    output cfg_interrupt_msi_fail,
    input  cfg_interrupt_msi_int,
    input  cfg_interrupt_msi_pending_status,
    input  cfg_interrupt_msi_pending_status_data_enable,
    input  cfg_interrupt_msi_pending_status_function_num,
    input  cfg_interrupt_msi_select,
    input  cfg_interrupt_msi_function_number,
    input  cfg_interrupt_msi_attr,
    input  cfg_interrupt_msi_tph_present,
    input  cfg_interrupt_msi_tph_type,
    input  cfg_interrupt_msi_tph_st_tag
  );
endinterface

// File: rtl/pcie_us_msi_ctrl.sv
// MSI interrupt controller for the UltraScale+ PCIe cfg_interrupt_msi_*
// interface. Request lines latch into pending bits, a round-robin arbiter
// picks one, and a single MSI is kept in flight with sent/fail/timeout
// handling and a retry back-off.
// Optional statistics counters: define PCIE_MSI_STATS_EN.
module pcie_us_msi_ctrl #(
  parameter int IRQ_COUNT   = 32,
  parameter int FUNC_NUM    = 0,
  parameter int TIMEOUT     = 1024,
  parameter int RETRY_DELAY = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IRQ_COUNT-1:0] irq_in,
  output logic                 irq_busy,
  pcie_us_msi_ctrl_if.master   msi
`ifdef PCIE_MSI_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] stat_sent_cnt,
  output logic [CNT_WIDTH-1:0] stat_fail_cnt,
  output logic [CNT_WIDTH-1:0] stat_timeout_cnt
`endif
);

  // One shared counter serves both the WAIT timeout and the BACKOFF delay.
  localparam int CNT_MAX = (TIMEOUT > RETRY_DELAY) ? TIMEOUT : RETRY_DELAY;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] BO_LAST = CW'(RETRY_DELAY - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_BACKOFF = 2'd3
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [4:0]           r_cur;
  logic [4:0]           r_ptr;
  logic [IRQ_COUNT-1:0] r_pending;
  logic [31:0]          r_msi_int;
  logic [31:0]          r_pend_status;
  logic                 r_de;

  state_t               w_state_nxt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [4:0]           w_cur_nxt;
  logic [4:0]           w_ptr_nxt;
  logic [31:0]          w_msi_nxt;

  logic                 w_en;
  logic [2:0]           w_mme;
  logic [2:0]           w_mme_c;
  logic [4:0]           w_mask;
  logic [4:0]           w_vec;
  logic [31:0]          w_onehot;
  logic [31:0]          w_pend32;
  logic                 w_found;
  logic [4:0]           w_sel;
  int                   w_sel_idx;
  logic [4:0]           w_ptr_inc;
  logic [IRQ_COUNT-1:0] w_clr;
  logic                 w_sent_ev;
  logic                 w_fail_ev;
  logic                 w_to_ev;
  logic                 w_unused;

  assign w_en     = msi.cfg_interrupt_msi_enable[FUNC_NUM];
  assign w_mme    = msi.cfg_interrupt_msi_mmenable[3*FUNC_NUM +: 3];
  assign w_pend32 = 32'(r_pending);

  // Allocated vector count is 2^min(MME,5); sources above it alias down.
  assign w_mme_c  = (w_mme > 3'd5) ? 3'd5 : w_mme;
  assign w_mask   = 5'((6'd1 << w_mme_c) - 6'd1);
  assign w_vec    = w_sel & w_mask;
  assign w_onehot = 32'd1 << w_vec;

  assign w_ptr_inc = (int'(r_cur) >= IRQ_COUNT - 1) ? 5'd0 : r_cur + 5'd1;

  // Sent wins over fail when both arrive together; a timeout is only
  // counted when neither response shows up on the last WAIT cycle.
  assign w_sent_ev = (r_state == S_WAIT) && msi.cfg_interrupt_msi_sent;
  assign w_fail_ev = (r_state == S_WAIT) && !msi.cfg_interrupt_msi_sent &&
                     msi.cfg_interrupt_msi_fail;
  assign w_to_ev   = (r_state == S_WAIT) && !msi.cfg_interrupt_msi_sent &&
                     !msi.cfg_interrupt_msi_fail && (r_cnt == TO_LAST);

  // Round-robin pick: first pending bit at or above ptr, wrapping.
  always_comb begin
    w_found   = 1'b0;
    w_sel     = 5'd0;
    w_sel_idx = 0;
    for (int i = 0; i < IRQ_COUNT; i++) begin
      w_sel_idx = int'(r_ptr) + i;
      if (w_sel_idx >= IRQ_COUNT) w_sel_idx = w_sel_idx - IRQ_COUNT;
      if (!w_found && w_pend32[5'(w_sel_idx)]) begin
        w_found = 1'b1;
        w_sel   = 5'(w_sel_idx);
      end
    end
  end

  // Clear mask for the in-flight source when the hard IP reports sent.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < IRQ_COUNT; i++) begin
      w_clr[i] = w_sent_ev && (r_cur == 5'(i));
    end
  end

  // Next-state and datapath-next decode for the issue FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cur_nxt   = r_cur;
    w_ptr_nxt   = r_ptr;
    w_msi_nxt   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_en && w_found) begin
          w_cur_nxt   = w_sel;
          w_msi_nxt   = w_onehot;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (msi.cfg_interrupt_msi_sent) begin
          w_ptr_nxt   = w_ptr_inc;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (msi.cfg_interrupt_msi_fail || (r_cnt == TO_LAST)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_BACKOFF;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      S_BACKOFF: begin
        if (r_cnt == BO_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state, counters, arbitration pointer and the MSI pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cur     <= '0;
      r_ptr     <= '0;
      r_msi_int <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cur     <= w_cur_nxt;
      r_ptr     <= w_ptr_nxt;
      r_msi_int <= w_msi_nxt;
    end
  end

  // Pending bits: new requests are OR-ed in after the clear, so set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | irq_in;
    end
  end

  // Registered pending mirror with a strobe marking each change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_status <= '0;
      r_de          <= 1'b0;
    end else begin
      r_pend_status <= w_pend32;
      r_de          <= (w_pend32 != r_pend_status);
    end
  end

`ifdef PCIE_MSI_STATS_EN
  logic [CNT_WIDTH-1:0] r_stat_sent;
  logic [CNT_WIDTH-1:0] r_stat_fail;
  logic [CNT_WIDTH-1:0] r_stat_to;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Saturating event counters for sent, fail and timeout outcomes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_sent <= '0;
      r_stat_fail <= '0;
      r_stat_to   <= '0;
    end else begin
      if (w_sent_ev) r_stat_sent <= sat_inc(r_stat_sent);
      if (w_fail_ev) r_stat_fail <= sat_inc(r_stat_fail);
      if (w_to_ev)   r_stat_to   <= sat_inc(r_stat_to);
    end
  end

  assign stat_sent_cnt    = r_stat_sent;
  assign stat_fail_cnt    = r_stat_fail;
  assign stat_timeout_cnt = r_stat_to;
`endif

  assign irq_busy = (|r_pending) || (r_state != S_IDLE);

  assign msi.cfg_interrupt_msi_int                       = r_msi_int;
  assign msi.cfg_interrupt_msi_pending_status            = r_pend_status;
  assign msi.cfg_interrupt_msi_pending_status_data_enable = r_de;
  assign msi.cfg_interrupt_msi_pending_status_function_num = 4'(FUNC_NUM);
  assign msi.cfg_interrupt_msi_select                    = 4'(FUNC_NUM);
  assign msi.cfg_interrupt_msi_function_number           = 4'(FUNC_NUM);
  assign msi.cfg_interrupt_msi_attr                      = 3'd0;
  assign msi.cfg_interrupt_msi_tph_present               = 1'b0;
  assign msi.cfg_interrupt_msi_tph_type                  = 2'd0;
  assign msi.cfg_interrupt_msi_tph_st_tag                = 9'd0;

  // Only one PF's enable/MME bits are consumed; the rest are ignored.
  assign w_unused = ^{msi.cfg_interrupt_msi_enable,
                      msi.cfg_interrupt_msi_mmenable,
                      (CNT_WIDTH > 0)};

endmodule

// File: tb/tb_pcie_us_msi_ctrl.sv
// Directed bench for pcie_us_msi_ctrl: single request, round-robin order,
// fail/retry back-off, timeout, MME aliasing, enable gating, set/clear
// collision and asynchronous reset mid-flight.
module tb_pcie_us_msi_ctrl;
  localparam int IRQ_COUNT   = 32;
  localparam int TIMEOUT     = 16;
  localparam int RETRY_DELAY = 64;
  localparam int CNT_WIDTH   = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [IRQ_COUNT-1:0] irq_in;
  logic                 irq_busy;
  int                   n_tests = 0;
  int                   n_fail  = 0;
  int                   waited;
  int                   bad;

  pcie_us_msi_ctrl_if u_if ();

`ifdef PCIE_MSI_STATS_EN
  logic [CNT_WIDTH-1:0] stat_sent_cnt;
  logic [CNT_WIDTH-1:0] stat_fail_cnt;
  logic [CNT_WIDTH-1:0] stat_timeout_cnt;
`endif

  pcie_us_msi_ctrl #(
    .IRQ_COUNT  (IRQ_COUNT),
    .FUNC_NUM   (0),
    .TIMEOUT    (TIMEOUT),
    .RETRY_DELAY(RETRY_DELAY),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .irq_in  (irq_in),
    .irq_busy(irq_busy),
    .msi     (u_if)
`ifdef PCIE_MSI_STATS_EN
    ,
    .stat_sent_cnt   (stat_sent_cnt),
    .stat_fail_cnt   (stat_fail_cnt),
    .stat_timeout_cnt(stat_timeout_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Poll for a non-zero msi_int for at most 'bound' cycles.
  task automatic wait_msi(input string tag, input int bound, output int cyc);
    cyc = 0;
    while (u_if.cfg_interrupt_msi_int == 32'd0 && cyc < bound) begin
      step(1);
      cyc++;
    end
    check(tag, 32'(u_if.cfg_interrupt_msi_int != 32'd0), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    irq_in = '0;
    u_if.cfg_interrupt_msi_sent = 1'b0;
    u_if.cfg_interrupt_msi_fail = 1'b0;
    u_if.cfg_interrupt_msi_enable = 4'h1;
    u_if.cfg_interrupt_msi_mmenable = 12'h005;
    step(3);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic pulse_irq(input logic [31:0] v);
    irq_in = v;
    step(1);
    irq_in = '0;
  endtask

  // Acknowledge the MSI currently shown: sent arrives in the first WAIT cycle.
  task automatic ack();
    step(1);
    u_if.cfg_interrupt_msi_sent = 1'b1;
    step(1);
    u_if.cfg_interrupt_msi_sent = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rr_msi [3];
    logic [31:0] rr_stat[3];
    rr_msi  = '{32'h1, 32'h4, 32'h10};
    rr_stat = '{32'h14, 32'h10, 32'h0};

    rst_n = 1'b0;
    irq_in = '0;
    u_if.cfg_interrupt_msi_sent = 1'b0;
    u_if.cfg_interrupt_msi_fail = 1'b0;
    u_if.cfg_interrupt_msi_enable = 4'h1;
    u_if.cfg_interrupt_msi_mmenable = 12'h005;
    step(2);

    // ---- reset values ----
    check("rst_msi_int", u_if.cfg_interrupt_msi_int, 32'h0);
    check("rst_pend_status", u_if.cfg_interrupt_msi_pending_status, 32'h0);
    check("rst_data_enable", 32'(u_if.cfg_interrupt_msi_pending_status_data_enable), 32'h0);
    check("rst_busy", 32'(irq_busy), 32'h0);
    check("const_func_num", 32'(u_if.cfg_interrupt_msi_function_number), 32'h0);
    rst_n = 1'b1;
    step(1);

    // ---- single request on irq 3 ----
    pulse_irq(32'h8);
    check("single_busy_pending", 32'(irq_busy), 32'h1);
    check("single_no_msi_yet", u_if.cfg_interrupt_msi_int, 32'h0);
    step(1);
    check("single_msi", u_if.cfg_interrupt_msi_int, 32'h8);
    check("single_status", u_if.cfg_interrupt_msi_pending_status, 32'h8);
    check("single_de_set", 32'(u_if.cfg_interrupt_msi_pending_status_data_enable), 32'h1);
    step(1);
    check("single_msi_one_cycle", u_if.cfg_interrupt_msi_int, 32'h0);
    step(3);
    u_if.cfg_interrupt_msi_sent = 1'b1;
    step(1);
    u_if.cfg_interrupt_msi_sent = 1'b0;
    check("single_busy_clear", 32'(irq_busy), 32'h0);
    check("single_status_lag", u_if.cfg_interrupt_msi_pending_status, 32'h8);
    step(1);
    check("single_status_clear", u_if.cfg_interrupt_msi_pending_status, 32'h0);
    check("single_de_clear", 32'(u_if.cfg_interrupt_msi_pending_status_data_enable), 32'h1);
    step(1);
    check("single_de_one_cycle", 32'(u_if.cfg_interrupt_msi_pending_status_data_enable), 32'h0);

    // ---- round-robin 0x15 ----
    do_reset();
    pulse_irq(32'h15);
    for (int k = 0; k < 3; k++) begin
      wait_msi("rr_arrive", 10, waited);
      check("rr_msi", u_if.cfg_interrupt_msi_int, rr_msi[k]);
      ack();
      step(1);
      check("rr_de", 32'(u_if.cfg_interrupt_msi_pending_status_data_enable), 32'h1);
      check("rr_status", u_if.cfg_interrupt_msi_pending_status, rr_stat[k]);
    end
    check("rr_busy_done", 32'(irq_busy), 32'h0);

    // ---- fail and retry on irq 7 ----
    do_reset();
    pulse_irq(32'h80);
    wait_msi("fail_arrive", 10, waited);
    check("fail_msi_first", u_if.cfg_interrupt_msi_int, 32'h80);
    step(1);
    u_if.cfg_interrupt_msi_fail = 1'b1;
    step(1);
    u_if.cfg_interrupt_msi_fail = 1'b0;
    bad = 0;
    for (int i = 0; i < RETRY_DELAY; i++) begin
      if (u_if.cfg_interrupt_msi_int != 32'd0) bad++;
      step(1);
    end
    if (u_if.cfg_interrupt_msi_int != 32'd0) bad++;
    check("fail_quiet_backoff", 32'(bad), 32'h0);
    check("fail_pending_kept", u_if.cfg_interrupt_msi_pending_status, 32'h80);
    check("fail_busy_backoff", 32'(irq_busy), 32'h1);
    step(1);
    check("fail_msi_retry", u_if.cfg_interrupt_msi_int, 32'h80);
    ack();
    check("fail_busy_after_sent", 32'(irq_busy), 32'h0);
`ifdef PCIE_MSI_STATS_EN
    check("stat_fail_cnt", 32'(stat_fail_cnt), 32'h1);
    check("stat_sent_cnt", 32'(stat_sent_cnt), 32'h1);
    check("stat_to_cnt_zero", 32'(stat_timeout_cnt), 32'h0);
`endif

    // ---- timeout on irq 1 ----
    do_reset();
    pulse_irq(32'h2);
    wait_msi("to_arrive", 10, waited);
    check("to_msi_first", u_if.cfg_interrupt_msi_int, 32'h2);
    step(1);
    wait_msi("to_reissue", 200, waited);
    check("to_reissue_gap", 32'(waited + 1), 32'(TIMEOUT + RETRY_DELAY + 2));
    check("to_msi_retry", u_if.cfg_interrupt_msi_int, 32'h2);
`ifdef PCIE_MSI_STATS_EN
    check("stat_to_cnt", 32'(stat_timeout_cnt), 32'h1);
    check("stat_fail_cnt_zero", 32'(stat_fail_cnt), 32'h0);
`endif
    ack();

    // ---- MME aliasing and enable gating ----
    do_reset();
    u_if.cfg_interrupt_msi_mmenable = 12'h002;
    pulse_irq(32'h40);
    wait_msi("alias_arrive", 10, waited);
    check("alias_msi", u_if.cfg_interrupt_msi_int, 32'h4);
    ack();
    u_if.cfg_interrupt_msi_enable = 4'h0;
    pulse_irq(32'h1);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (u_if.cfg_interrupt_msi_int != 32'd0) bad++;
      step(1);
    end
    check("gate_quiet", 32'(bad), 32'h0);
    check("gate_status_held", u_if.cfg_interrupt_msi_pending_status, 32'h1);
    check("gate_busy", 32'(irq_busy), 32'h1);
    u_if.cfg_interrupt_msi_enable = 4'h1;
    wait_msi("gate_arrive", 2, waited);
    check("gate_msi", u_if.cfg_interrupt_msi_int, 32'h1);
    ack();

    // ---- set/clear collision, then async reset mid-WAIT ----
    do_reset();
    pulse_irq(32'h4);
    wait_msi("coll_arrive", 10, waited);
    check("coll_msi_first", u_if.cfg_interrupt_msi_int, 32'h4);
    step(1);
    u_if.cfg_interrupt_msi_sent = 1'b1;
    irq_in = 32'h4;
    step(1);
    u_if.cfg_interrupt_msi_sent = 1'b0;
    irq_in = '0;
    check("coll_pending_kept", 32'(irq_busy), 32'h1);
    wait_msi("coll_second_arrive", 5, waited);
    check("coll_msi_second", u_if.cfg_interrupt_msi_int, 32'h4);
    step(1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(irq_busy), 32'h0);
    check("arst_status", u_if.cfg_interrupt_msi_pending_status, 32'h0);
    check("arst_msi", u_if.cfg_interrupt_msi_int, 32'h0);
    step(2);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (u_if.cfg_interrupt_msi_int != 32'd0 || irq_busy) bad++;
    end
    check("arst_no_retry", 32'(bad), 32'h0);
    pulse_irq(32'h20);
    wait_msi("arst_new_arrive", 10, waited);
    check("arst_new_msi", u_if.cfg_interrupt_msi_int, 32'h20);
    ack();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
